mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Three-way round-robin arbiter that shares the single-port 2K x 32 distributed instruction/data memory among the ARM host path (AXI-Lite decoder), the RISC-V data port and the RISC-V instruction-fetch port. It sits between those requesters and the memory. It issues single-cycle grants, drives the memory port, and registers read data. It returns read data with a per-port valid one cycle after grant. CPU requests are masked while the RISC-V core is held in reset, so the host can load the memory image. Saturating per-port grant counters support bandwidth profiling.

## Interface
- CNT_W, 16, width of each grant counter
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_rst  in  1  RISC-V reset (riscv_rst); when 1, ports 1 and 2 are masked
- h_req / d_req / i_req  in  1  request, ports 0 (host) / 1 (CPU data) / 2 (CPU ifetch)
- h_we / d_we  in  1  write enable (ifetch port is read-only)
- h_addr / d_addr / i_addr  in  11  word address
- h_wdata / d_wdata  in  32  write data
- h_gnt / d_gnt / i_gnt  out  1  combinational grant; access performed this cycle
- h_rvalid / d_rvalid / i_rvalid  out  1  read data valid, one-cycle pulse
- rdata  out  32  registered read data, shared by all ports
- mem_addr  out  11  memory address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  32  asynchronous memory read data
- clr_cnt  in  1  synchronous clear of all grant counters
- h_cnt / d_cnt / i_cnt  out  CNT_W  saturating grant counts

## Operation
- Effective request: h_eff = h_req; d_eff = d_req & ~cpu_rst; i_eff = i_req & ~cpu_rst.
- Round-robin pointer `last` holds 2 bits with values 0..2; value 3 is unreachable.
- Search order starts at (last+1) mod 3 and wraps. The first port with an effective request is granted.
- Exactly one gnt, or none, is high per cycle.
- `last` loads the granted index only on a cycle with a grant. Otherwise it holds.
- Granted port drives the memory: mem_addr = its addr, mem_we = its we (0 for ifetch), mem_wdata = its wdata when writing, else 0.
- With no grant, mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Read grant (we = 0): rdata <= mem_rdata at the end of the grant cycle, and that port's rvalid = 1 for the next cycle.
- rdata holds its value until the next read grant. Write grants do not touch rdata and raise no rvalid.
- Requesters hold req/addr/we/wdata stable until they sample gnt = 1. After that they may drop req or present the next request in the following cycle, which gives back-to-back throughput of 1 access per cycle.
- Counters: a grant to a port increments its counter, saturating at 2^CNT_W-1. clr_cnt = 1 forces all counters to 0, and clear wins over a same-cycle grant.
- cpu_rst rising while a CPU read is in flight (grant in cycle N, cpu_rst = 1 in cycle N+1) suppresses that port's rvalid in N+1. rdata still updates.

## Timing
- Reset values: last = 2 (host searched first), rdata = 0, all rvalid = 0, all counters = 0.
- While rst is high, all gnt = 0 and mem_we = 0. Combinational outputs are forced idle while rst is high.
- Grant and memory access happen in the same cycle as the request (0-cycle arbitration latency). Read data arrives 1 cycle after the grant.
- All three requesting continuously gives the grant sequence host, data, ifetch, host, ... Each port gets one grant per 3 cycles, so the worst-case wait is 2 cycles.
- A single requester is granted every cycle.
- Reset asserted mid-transfer clears rvalid and the pointer immediately, since reset is asynchronous. No write is issued while rst is high.

## Test plan
- Reset, then host write addr 0x005 data 0xDEADBEEF, then host read 0x005 -> h_gnt in both request cycles; h_rvalid=1 the cycle after the read grant with rdata=0xDEADBEEF; h_cnt=2.
- cpu_rst=1 with d_req and i_req held high -> no d_gnt/i_gnt; host still granted every cycle. Deassert cpu_rst -> d_gnt in the next cycle.
- All three request reads continuously for 9 cycles -> grant order H,D,I repeated 3 times; each counter = 3; each rvalid pulses 1 cycle after its grant.
- Data write and ifetch read in the same cycle with last=0 -> d_gnt first (mem_we=1); i_gnt next cycle; i_rvalid one cycle later; rdata unchanged by the write.
- CNT_W=4, host requests 20 cycles -> h_cnt saturates at 15. Assert clr_cnt together with a grant -> h_cnt=0.
- Assert rst in the cycle after a read grant -> rvalid=0 and rdata=0 immediately; after release, the first grant goes to the host when all three request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Three-way round-robin arbiter sharing one single-port 2K x 32
//            memory between the host path (port 0), the RISC-V data port
//            (port 1) and the RISC-V instruction-fetch port (port 2).
//            Grants are combinational, and the access happens in the grant
//            cycle. Read data is registered and flagged with a per-port
//            rvalid pulse one cycle later.
// Ports    : clk, rst (async, active-high), cpu_rst (masks ports 1/2)
//            h_/d_/i_ req, we, addr, wdata  - requester side
//            h_/d_/i_ gnt, rvalid, rdata     - requester responses
//            mem_addr/mem_wdata/mem_we/mem_rdata - memory port
//            clr_cnt, h_/d_/i_ cnt           - saturating grant counters
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_rst,
    input  logic             h_req,
    input  logic             d_req,
    input  logic             i_req,
    input  logic             h_we,
    input  logic             d_we,
    input  logic [10:0]      h_addr,
    input  logic [10:0]      d_addr,
    input  logic [10:0]      i_addr,
    input  logic [31:0]      h_wdata,
    input  logic [31:0]      d_wdata,
    output logic             h_gnt,
    output logic             d_gnt,
    output logic             i_gnt,
    output logic             h_rvalid,
    output logic             d_rvalid,
    output logic             i_rvalid,
    output logic [31:0]      rdata,
    output logic [10:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_we,
    input  logic [31:0]      mem_rdata,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic [CNT_W-1:0] i_cnt
);

    localparam logic [1:0] c_LAST_RST = 2'd2;   // host is searched first after reset

    logic [2:0]       w_eff;
    logic [2:0]       w_gnt;
    logic [1:0]       w_gnt_idx;
    logic             w_any;
    logic             w_rd;
    logic [10:0]      w_mem_addr;
    logic [31:0]      w_mem_wdata;
    logic             w_mem_we;

    logic [1:0]       r_last;
    logic [2:0]       r_rvalid;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt [3];

    // CPU ports are masked while the core is in reset; everything is idle in reset.
    always_comb begin
        w_eff = {i_req & ~cpu_rst, d_req & ~cpu_rst, h_req};
        if (rst) begin
            w_eff = 3'b000;
        end
    end

    // Search starts one past the last granted port and wraps.
    // The unreachable value 3 falls into the default (host-first) order.
    always_comb begin
        w_gnt = 3'b000;
        case (r_last)
            2'd0: begin
                if      (w_eff[1]) w_gnt = 3'b010;
                else if (w_eff[2]) w_gnt = 3'b100;
                else if (w_eff[0]) w_gnt = 3'b001;
            end
            2'd1: begin
                if      (w_eff[2]) w_gnt = 3'b100;
                else if (w_eff[0]) w_gnt = 3'b001;
                else if (w_eff[1]) w_gnt = 3'b010;
            end
            default: begin
                if      (w_eff[0]) w_gnt = 3'b001;
                else if (w_eff[1]) w_gnt = 3'b010;
                else if (w_eff[2]) w_gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_gnt_idx = 2'd0;
        if (w_gnt[1]) w_gnt_idx = 2'd1;
        if (w_gnt[2]) w_gnt_idx = 2'd2;
    end

    assign w_any = |w_gnt;

    // Memory port mux; write data is zeroed on reads so the bus is quiet.
    always_comb begin
        w_mem_addr  = 11'd0;
        w_mem_wdata = 32'd0;
        w_mem_we    = 1'b0;
        if (w_gnt[0]) begin
            w_mem_addr  = h_addr;
            w_mem_we    = h_we;
            w_mem_wdata = h_we ? h_wdata : 32'd0;
        end else if (w_gnt[1]) begin
            w_mem_addr  = d_addr;
            w_mem_we    = d_we;
            w_mem_wdata = d_we ? d_wdata : 32'd0;
        end else if (w_gnt[2]) begin
            w_mem_addr  = i_addr;
        end
    end

    assign w_rd = w_any & ~w_mem_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= c_LAST_RST;
            r_rvalid <= 3'b000;
            r_rdata  <= 32'd0;
        end else begin
            if (w_any) begin
                r_last <= w_gnt_idx;
            end
            r_rvalid <= w_rd ? w_gnt : 3'b000;
            if (w_rd) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (clr_cnt) begin
                    r_cnt[gi] <= '0;
                end else if (w_gnt[gi] && (r_cnt[gi] != {CNT_W{1'b1}})) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign h_gnt     = w_gnt[0];
    assign d_gnt     = w_gnt[1];
    assign i_gnt     = w_gnt[2];
    // A CPU read in flight when cpu_rst rises loses its valid pulse; rdata still updates.
    assign h_rvalid  = r_rvalid[0];
    assign d_rvalid  = r_rvalid[1] & ~cpu_rst;
    assign i_rvalid  = r_rvalid[2] & ~cpu_rst;
    assign rdata     = r_rdata;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;
    assign mem_we    = w_mem_we;
    assign h_cnt     = r_cnt[0];
    assign d_cnt     = r_cnt[1];
    assign i_cnt     = r_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A behavioural model
//            (round-robin search with modular arithmetic, an array memory,
//            integer counters) is compared with the DUT on every falling
//            edge. Directed sequences add hand-computed expectations, and a
//            randomized phase follows them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_rst = 1'b0;
    logic          h_req = 1'b0, d_req = 1'b0, i_req = 1'b0;
    logic          h_we = 1'b0, d_we = 1'b0;
    logic [10:0]   h_addr = '0, d_addr = '0, i_addr = '0;
    logic [31:0]   h_wdata = '0, d_wdata = '0;
    logic          h_gnt, d_gnt, i_gnt;
    logic          h_rvalid, d_rvalid, i_rvalid;
    logic [31:0]   rdata;
    logic [10:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] h_cnt, d_cnt, i_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cpu_rst(cpu_rst),
        .h_req(h_req), .d_req(d_req), .i_req(i_req),
        .h_we(h_we), .d_we(d_we),
        .h_addr(h_addr), .d_addr(d_addr), .i_addr(i_addr),
        .h_wdata(h_wdata), .d_wdata(d_wdata),
        .h_gnt(h_gnt), .d_gnt(d_gnt), .i_gnt(i_gnt),
        .h_rvalid(h_rvalid), .d_rvalid(d_rvalid), .i_rvalid(i_rvalid),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .clr_cnt(clr_cnt),
        .h_cnt(h_cnt), .d_cnt(d_cnt), .i_cnt(i_cnt)
    );

    // Memory the DUT drives (asynchronous read, synchronous write)
    logic [31:0] ram [0:2047];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] ref_mem [0:2047];
    int          m_last;
    bit  [2:0]   m_rv;
    logic [31:0] m_rdata;
    int          m_cnt [3];
    bit  [2:0]   e_eff;
    int          e_g, e_p;
    logic [10:0] e_addr;
    logic        e_we;
    logic [31:0] e_wd;
    logic [2:0]  e_gv;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_gnt", 32'({i_gnt, d_gnt, h_gnt}), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_rvalid", 32'({i_rvalid, d_rvalid, h_rvalid}), 32'd0);
            check("rst_rdata", rdata, 32'd0);
            check("rst_cnt", 32'({i_cnt, d_cnt, h_cnt}), 32'd0);
            m_last  = 2;
            m_rv    = 3'b000;
            m_rdata = 32'd0;
            for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        end else begin
            e_eff[0] = h_req;
            e_eff[1] = d_req & ~cpu_rst;
            e_eff[2] = i_req & ~cpu_rst;
            e_g = -1;
            for (int k = 1; k <= 3; k++) begin
                e_p = (m_last + k) % 3;
                if (e_g < 0 && e_eff[e_p]) e_g = e_p;
            end
            e_addr = '0; e_we = 1'b0; e_wd = '0; e_gv = 3'b000;
            case (e_g)
                0: begin e_addr = h_addr; e_we = h_we; e_wd = h_we ? h_wdata : 32'd0; end
                1: begin e_addr = d_addr; e_we = d_we; e_wd = d_we ? d_wdata : 32'd0; end
                2: begin e_addr = i_addr; end
                default: ;
            endcase
            if (e_g >= 0) e_gv = 3'b001 << e_g;

            check("gnt", 32'({i_gnt, d_gnt, h_gnt}), 32'(e_gv));
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("mem_wdata", mem_wdata, e_wd);
            check("h_rvalid", 32'(h_rvalid), 32'(m_rv[0]));
            check("d_rvalid", 32'(d_rvalid), 32'(m_rv[1] & ~cpu_rst));
            check("i_rvalid", 32'(i_rvalid), 32'(m_rv[2] & ~cpu_rst));
            check("rdata", rdata, m_rdata);
            check("h_cnt", 32'(h_cnt), 32'(m_cnt[0]));
            check("d_cnt", 32'(d_cnt), 32'(m_cnt[1]));
            check("i_cnt", 32'(i_cnt), 32'(m_cnt[2]));

            // advance model to the state after the coming rising edge
            m_rv = 3'b000;
            if (e_g >= 0) begin
                m_last = e_g;
                if (e_we) ref_mem[e_addr] = e_wd;
                else begin
                    m_rdata = ref_mem[e_addr];
                    m_rv    = e_gv;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (clr_cnt) m_cnt[k] = 0;
                else if (e_g == k && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic idle_all();
        h_req = 0; d_req = 0; i_req = 0; h_we = 0; d_we = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int a = 0; a < 2048; a++) begin
            ram[a] = 32'd0;
            ref_mem[a] = 32'd0;
        end
        mid();
        check("lit_rst_rdata", rdata, 32'd0);
        check("lit_rst_hcnt", 32'(h_cnt), 32'd0);
        tick(); tick();
        rst = 0;

        // host write then read of 0x005
        h_req = 1; h_we = 1; h_addr = 11'h005; h_wdata = 32'hDEADBEEF;
        mid();
        check("lit_t1_wr_gnt", 32'(h_gnt), 32'd1);
        check("lit_t1_wr_we", 32'(mem_we), 32'd1);
        tick();
        h_we = 0; h_wdata = 0;
        mid();
        check("lit_t1_rd_gnt", 32'(h_gnt), 32'd1);
        check("lit_t1_rd_we", 32'(mem_we), 32'd0);
        tick();
        h_req = 0;
        mid();
        check("lit_t1_rvalid", 32'(h_rvalid), 32'd1);
        check("lit_t1_rdata", rdata, 32'hDEADBEEF);
        check("lit_t1_hcnt", 32'(h_cnt), 32'd2);

        // cpu_rst masks CPU ports
        tick();
        cpu_rst = 1; h_req = 1; d_req = 1; i_req = 1;
        d_addr = 11'd1; i_addr = 11'd2;
        for (int k = 0; k < 3; k++) begin
            mid();
            check("lit_t2_cpu_masked", 32'({i_gnt, d_gnt}), 32'd0);
            check("lit_t2_host_gnt", 32'(h_gnt), 32'd1);
            tick();
        end
        cpu_rst = 0; h_req = 0;
        mid();
        check("lit_t2_dgnt_after", 32'(d_gnt), 32'd1);

        // reset, then all three continuously: H,D,I x3
        tick();
        idle_all(); rst = 1;
        tick();
        rst = 0; h_req = 1; d_req = 1; i_req = 1;
        for (int k = 0; k < 9; k++) begin
            mid();
            check("lit_t3_order", 32'({i_gnt, d_gnt, h_gnt}), 32'(3'b001 << (k % 3)));
            tick();
        end
        idle_all();
        mid();
        check("lit_t3_cnts", 32'({i_cnt, d_cnt, h_cnt}), 32'({4'd3, 4'd3, 4'd3}));
        check("lit_t3_irvalid", 32'(i_rvalid), 32'd1);

        // last=0, then data write and ifetch read together
        tick();
        h_req = 1; h_addr = 11'h005;
        tick();
        h_req = 0; d_req = 1; d_we = 1; d_addr = 11'd7; d_wdata = 32'h12345678;
        i_req = 1; i_addr = 11'h005;
        mid();
        check("lit_t4_dgnt", 32'({i_gnt, d_gnt}), 32'b01);
        check("lit_t4_we", 32'(mem_we), 32'd1);
        tick();
        d_req = 0; d_we = 0;
        mid();
        check("lit_t4_igrant", 32'(i_gnt), 32'd1);
        check("lit_t4_rdata_kept", rdata, 32'hDEADBEEF);
        tick();
        i_req = 0;
        mid();
        check("lit_t4_irvalid", 32'(i_rvalid), 32'd1);
        check("lit_t4_rdata", rdata, 32'hDEADBEEF);

        // saturation and clear-wins
        tick();
        h_req = 1; h_addr = 11'd3;
        repeat (20) @(posedge clk);
        #1;
        mid();
        check("lit_t5_sat", 32'(h_cnt), 32'd15);
        tick();
        clr_cnt = 1;
        tick();
        clr_cnt = 0; h_req = 0;
        mid();
        check("lit_t5_clr", 32'(h_cnt), 32'd0);

        // reset right after a read grant
        tick();
        h_req = 1; h_addr = 11'h005;
        tick();
        h_req = 0; rst = 1;
        #1;
        check("lit_t6_rvalid", 32'(h_rvalid), 32'd0);
        check("lit_t6_rdata", rdata, 32'd0);
        tick();
        rst = 0; h_req = 1; d_req = 1; i_req = 1;
        mid();
        check("lit_t6_host_first", 32'({i_gnt, d_gnt, h_gnt}), 32'b001);
        tick();
        idle_all();

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) cpu_rst = ~cpu_rst;
            clr_cnt = ($urandom_range(0, 39) == 0);
            h_req   = 1'($urandom);
            d_req   = 1'($urandom);
            i_req   = 1'($urandom);
            h_we    = 1'($urandom);
            d_we    = 1'($urandom);
            h_addr  = 11'($urandom_range(0, 15));
            d_addr  = 11'($urandom_range(0, 15));
            i_addr  = 11'($urandom_range(0, 15));
            h_wdata = $urandom;
            d_wdata = $urandom;
        end
        tick();
        idle_all(); rst = 0; clr_cnt = 0;
        mid();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
